midi_decoder: RTL and testbench

MIDI_DECODER -- requirements
Module: midi_decoder

---
 rtl/midi_decoder_pkg.sv | 32 +++
 rtl/midi_decoder.sv | 121 ++++++++++++
 tb/tb_midi_decoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/midi_decoder_pkg.sv
// rtl/midi_decoder_pkg.sv - MIDI status codes, decoded message type and decoder states.
package MIDI;

  localparam logic [3:0] NOTE_OFF       = 4'h8;
  localparam logic [3:0] NOTE_ON        = 4'h9;
  localparam logic [3:0] CONTROL_CHANGE = 4'hB;

  localparam logic [6:0] VOLUME = 7'd7;

  // Kind members carry a prefix so they do not collide with the status codes above.
  typedef enum logic [1:0] {
    KIND_NOTE_OFF       = 2'd0,
    KIND_NOTE_ON        = 2'd1,
    KIND_CONTROL_CHANGE = 2'd2
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] channel;
    logic [6:0] key;
    logic [6:0] value;
  } message_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA1 = 3'd1,
    DATA2 = 3'd2,
    SKIP1 = 3'd3,
    SKIP2 = 3'd4
  } state_t;

endpackage

// File: rtl/midi_decoder.sv
// rtl/midi_decoder.sv - MIDI byte stream to channel-message decoder with running status.
module midi_decoder
  import MIDI::*;
(
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] data_in,
  input  logic       data_in_ready,
  output message_t   message,
  output logic       message_ready
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_status_hi;
  logic [3:0] r_channel;
  logic [6:0] r_key;
  message_t   r_message;
  logic       r_message_ready;

  logic       w_load_status;
  logic       w_clear_status;
  logic       w_load_key;
  logic       w_emit;
  kind_t      w_kind;

  always_ff @(posedge clock_50_000_000) begin
    if (reset_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_load_status  = 1'b0;
    w_clear_status = 1'b0;
    w_load_key     = 1'b0;
    w_emit         = 1'b0;
    if (data_in_ready) begin
      if (data_in[7]) begin
        if (data_in[7:4] == 4'hF) begin
          // System common clears running status; real-time (bit3 set) is transparent.
          if (!data_in[3]) begin
            w_next_state   = IDLE;
            w_clear_status = 1'b1;
          end
        end else begin
          w_load_status = 1'b1;
          case (data_in[7:4])
            NOTE_OFF, NOTE_ON, CONTROL_CHANGE: w_next_state = DATA1;
            4'hA, 4'hE:                        w_next_state = SKIP2;
            default:                           w_next_state = SKIP1;
          endcase
        end
      end else begin
        case (r_state)
          DATA1: begin
            w_load_key   = 1'b1;
            w_next_state = DATA2;
          end
          DATA2: begin
            w_emit       = 1'b1;
            w_next_state = DATA1;
          end
          SKIP2: w_next_state = SKIP1;
          SKIP1: begin
            if (r_status_hi == 4'hC || r_status_hi == 4'hD) begin
              w_next_state = SKIP1;
            end else begin
              w_next_state = SKIP2;
            end
          end
          default: w_next_state = r_state;
        endcase
      end
    end
  end

  always_comb begin
    w_kind = KIND_NOTE_OFF;
    if (r_status_hi == CONTROL_CHANGE) begin
      w_kind = KIND_CONTROL_CHANGE;
    end else if (r_status_hi == NOTE_ON && data_in[6:0] != 7'd0) begin
      w_kind = KIND_NOTE_ON;
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset_l) begin
      r_status_hi     <= 4'h0;
      r_channel       <= 4'h0;
      r_key           <= 7'd0;
      r_message       <= '0;
      r_message_ready <= 1'b0;
    end else begin
      r_message_ready <= w_emit;
      if (w_clear_status) begin
        r_status_hi <= 4'h0;
        r_channel   <= 4'h0;
      end else if (w_load_status) begin
        r_status_hi <= data_in[7:4];
        r_channel   <= data_in[3:0];
      end
      if (w_load_key) begin
        r_key <= data_in[6:0];
      end
      if (w_emit) begin
        r_message.kind    <= w_kind;
        r_message.channel <= r_channel;
        r_message.key     <= r_key;
        r_message.value   <= data_in[6:0];
      end
    end
  end

  assign message       = r_message;
  assign message_ready = r_message_ready;

endmodule

// File: tb/tb_midi_decoder.sv
// tb/tb_midi_decoder.sv - scoreboard bench for midi_decoder with a byte-level reference model.
module tb_midi_decoder;
  import MIDI::*;

  logic       clk = 1'b0;
  logic       reset_l;
  logic [7:0] data_in;
  logic       data_in_ready;
  message_t   message;
  logic       message_ready;

  always #10 clk = ~clk;

  midi_decoder dut (
    .clock_50_000_000(clk),
    .reset_l         (reset_l),
    .data_in         (data_in),
    .data_in_ready   (data_in_ready),
    .message         (message),
    .message_ready   (message_ready)
  );

  int       n_tests = 0;
  int       n_fail  = 0;
  message_t exp_q[$];

  logic [7:0] m_status;
  logic [6:0] m_data[$];
  message_t   m_last;

  function automatic message_t mk(kind_t k, logic [3:0] c, logic [6:0] key, logic [6:0] v);
    message_t m;
    m.kind    = k;
    m.channel = c;
    m.key     = key;
    m.value   = v;
    return m;
  endfunction

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_status = 8'h00;
    m_data.delete();
    m_last = '0;
  endfunction

  // Message-level view: remember the running status byte, collect data bytes,
  // and emit once the status's data count is complete.
  function automatic void model_byte(logic [7:0] b);
    int       need;
    message_t e;
    logic [3:0] hi;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_status = 8'h00;
      m_data.delete();
      return;
    end
    if (b[7]) begin
      m_status = b;
      m_data.delete();
      return;
    end
    if (m_status == 8'h00) return;
    m_data.push_back(b[6:0]);
    hi   = m_status[7:4];
    need = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
    if (m_data.size() == need) begin
      if (hi == 4'h8 || hi == 4'h9 || hi == 4'hB) begin
        if (hi == 4'hB)                   e.kind = KIND_CONTROL_CHANGE;
        else if (hi == 4'h9 && m_data[1] != 0) e.kind = KIND_NOTE_ON;
        else                              e.kind = KIND_NOTE_OFF;
        e.channel = m_status[3:0];
        e.key     = m_data[0];
        e.value   = m_data[1];
        exp_q.push_back(e);
        m_last = e;
      end
      m_data.delete();
    end
  endfunction

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic send(input logic [7:0] b);
    data_in       = b;
    data_in_ready = 1'b1;
    model_byte(b);
    @(negedge clk);
    data_in_ready = 1'b0;
    data_in       = 8'($urandom);
  endtask

  task automatic do_reset(input bit with_byte, input logic [7:0] b);
    reset_l = 1'b1;
    if (with_byte) begin
      data_in       = b;
      data_in_ready = 1'b1;
    end
    model_reset();
    @(negedge clk);
    reset_l       = 1'b0;
    data_in_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_hold"}, message, m_last);
  endtask

  always @(negedge clk) begin
    if (message_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got message %h with message_ready=1, expected no pulse", message);
      end else begin
        check("pulse_msg", message, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_l       = 1'b1;
    data_in       = 8'h00;
    data_in_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_l = 1'b0;
    check("reset_message", message, 0);
    check("reset_ready", message_ready, 0);

    send(8'h90); send(8'd10); send(8'd80);
    drain("note_on");
    check("note_on_val", message, mk(KIND_NOTE_ON, 4'd0, 7'd10, 7'd80));

    send(8'h90); send(8'd20); send(8'd0);
    drain("vel0");
    check("vel0_val", message, mk(KIND_NOTE_OFF, 4'd0, 7'd20, 7'd0));

    send(8'h80); send(8'd30); send(8'd0);
    drain("note_off");
    check("note_off_val", message, mk(KIND_NOTE_OFF, 4'd0, 7'd30, 7'd0));

    send(8'hB0); send({1'b0, VOLUME}); send(8'd60);
    drain("cc");
    check("cc_val", message, mk(KIND_CONTROL_CHANGE, 4'd0, VOLUME, 7'd60));

    send(8'hC0); send(8'd50); send(8'h90); send(8'd60); send(8'd80);
    drain("prog_then_note");
    check("prog_then_note_val", message, mk(KIND_NOTE_ON, 4'd0, 7'd60, 7'd80));

    send(8'h93); send(8'd64); send(8'hF8); send(8'd100);
    send(8'd65); send(8'hF8); send(8'd90);
    drain("running");
    check("running_val", message, mk(KIND_NOTE_ON, 4'd3, 7'd65, 7'd90));

    send(8'h90); send(8'd10);
    do_reset(1'b0, 8'h00);
    send(8'd80);
    drain("reset_mid");
    check("reset_mid_val", message, 0);

    send(8'h90); send(8'd11);
    do_reset(1'b1, 8'd77);
    send(8'd33); send(8'd44);
    drain("reset_byte");
    check("reset_byte_val", message, 0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 62) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h00 : {1'b0, 7'($urandom)};
      end else if (r < 88) begin
        case ($urandom_range(0, 6))
          0: b = 8'h80; 1: b = 8'h90; 2: b = 8'hB0; 3: b = 8'hA0;
          4: b = 8'hC0; 5: b = 8'hD0; default: b = 8'hE0;
        endcase
        b[3:0] = 4'($urandom);
      end else if (r < 95) begin
        b = 8'hF8 | 8'($urandom_range(0, 7));
      end else if (r < 98) begin
        b = 8'hF0 | 8'($urandom_range(0, 7));
      end else begin
        b = 8'h00;
        do_reset($urandom_range(0, 1) == 1, 8'($urandom));
        continue;
      end
      send(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
